io_uart_bridge: RTL and testbench



---
 rtl/io_defs.sv | 31 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/io_uart_bridge.sv | 171 +++++++++++++++++
 tb/tb_io_uart_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_defs.sv
// Shared IO map constants for the core IO port: word-select bits, status bit
// positions and TX FSM state encodings.
package io_defs;

    localparam int unsigned IO_LED_BIT         = 0;
    localparam int unsigned IO_UART_DATA_BIT   = 1;
    localparam int unsigned IO_UART_STATUS_BIT = 2;

    localparam int unsigned ST_OVF  = 10;
    localparam int unsigned ST_FULL = 9;
    localparam int unsigned ST_BUSY = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic busy, input logic [3:0] count);
        logic [31:0] w;
        w          = '0;
        w[ST_OVF]  = ovf;
        w[ST_FULL] = full;
        w[ST_BUSY] = busy;
        w[3:0]     = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Flags come from registered pointers, so a push while full is refused
    // even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/io_uart_bridge.sv
// IO slave for the core IO port: LED register, buffered 8N1 UART transmitter
// and a combinational status word for FIFO-space polling.
module io_uart_bridge
    import io_defs::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 10000000,
    parameter int unsigned BAUD_RATE   = 1000000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [5:0]  LEDS,
    output logic        UART_TX
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    logic [2:0]  sel;
    logic        led_we;
    logic        data_we;
    logic        stat_we;
    logic        unused_bits;

    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic        ovf;
    logic        busy;
    logic [31:0] count_wide;
    logic [3:0]  count_disp;

    tx_state_t   state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;

    assign sel     = IO_mem_addr[4:2];
    assign led_we  = IO_mem_wr && sel[IO_LED_BIT];
    assign data_we = IO_mem_wr && sel[IO_UART_DATA_BIT];
    assign stat_we = IO_mem_wr && sel[IO_UART_STATUS_BIT];
    assign unused_bits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0],
                           IO_mem_wdata[31:11], IO_mem_wdata[9:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (data_we),
        .pop    (fifo_pop),
        .din    (IO_mem_wdata[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            LEDS <= '0;
            ovf  <= 1'b0;
        end else begin
            if (led_we) LEDS <= IO_mem_wdata[5:0];
            if (stat_we && IO_mem_wdata[ST_OVF]) ovf <= 1'b0;
            if (data_we && fifo_full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= TX_IDLE;
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            shift    <= '0;
            UART_TX  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            UART_TX  <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = UART_TX;
        fifo_pop   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_n    = fifo_dout;
                    tx_n       = 1'b0;
                    state_n    = TX_START;
                    baud_cnt_n = BAUD_LOAD;
                end
            end
            TX_START: begin
                if (baud_cnt == '0) begin
                    state_n    = TX_DATA;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                    baud_cnt_n = BAUD_LOAD;
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            TX_DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        // The registered line takes the bit that becomes shift[0].
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            TX_STOP: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_LOAD;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_dout;
                        tx_n     = 1'b0;
                        state_n  = TX_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = TX_IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign busy       = (state != TX_IDLE) || !fifo_empty;
    assign count_wide = 32'(fifo_count);
    assign count_disp = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

    assign IO_mem_rdata = sel[IO_UART_STATUS_BIT]
                        ? status_word(ovf, fifo_full, busy, count_disp)
                        : '0;

endmodule

// File: tb/tb_io_uart_bridge.sv
// Directed bench for io_uart_bridge: scoreboard of written bytes checked
// against frames decoded from UART_TX, plus status/LED/reset checks.
module tb_io_uart_bridge;

    localparam int unsigned DIV   = 10;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
        logic        stop_ok;
    } rx_t;

    logic        clk;
    logic        resetn;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;
    logic [5:0]  LEDS;
    logic        UART_TX;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] sb_q[$];
    rx_t        rx_q[$];

    io_uart_bridge #(
        .CLK_FREQ_HZ (10000000),
        .BAUD_RATE   (1000000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .IO_mem_addr  (IO_mem_addr),
        .IO_mem_wdata (IO_mem_wdata),
        .IO_mem_wr    (IO_mem_wr),
        .IO_mem_rdata (IO_mem_rdata),
        .LEDS         (LEDS),
        .UART_TX      (UART_TX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        IO_mem_addr  = a;
        IO_mem_wdata = d;
        IO_mem_wr    = 1'b1;
        @(negedge clk);
        IO_mem_wr    = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] v);
        IO_mem_addr = 32'h10;
        #1 v = IO_mem_rdata;
    endtask

    task automatic expect_frame(input string tag, output int unsigned start);
        rx_t  r;
        logic got;
        logic [7:0] exp_b;
        got = 1'b0;
        start = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rx_q.size() > 0) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_present"}, {31'b0, got}, 32'd1);
        if (got) begin
            r = rx_q.pop_front();
            start = r.start;
            check({tag, "_sb_nonempty"}, {31'b0, sb_q.size() > 0}, 32'd1);
            exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            check({tag, "_data"}, {24'b0, r.data}, {24'b0, exp_b});
            check({tag, "_stop"}, {31'b0, r.stop_ok}, 32'd1);
        end
    endtask

    // Frame monitor: samples mid-bit; a frame cut by reset is discarded.
    task automatic mon_wait(input int n, inout bit ab);
        for (int i = 0; i < n && !ab; i++) begin
            @(negedge clk);
            if (!resetn) ab = 1'b1;
        end
    endtask

    initial begin
        rx_t r;
        bit  ab;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (resetn && UART_TX === 1'b0) begin
                r.start = cyc;
                ab = 1'b0;
                b  = '0;
                mon_wait(DIV + DIV/2, ab);
                for (int k = 0; k < 8; k++) begin
                    if (!ab) begin
                        b[k] = UART_TX;
                        mon_wait(DIV, ab);
                    end
                end
                if (!ab) begin
                    r.data    = b;
                    r.stop_ok = (UART_TX === 1'b1);
                    rx_q.push_back(r);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  pat;
        logic [7:0]  burst [9];
        logic        exp_bit;
        int          mcount;
        logic        exp_ovf;
        int unsigned s_prev, s_cur;

        resetn       = 1'b0;
        IO_mem_addr  = '0;
        IO_mem_wdata = '0;
        IO_mem_wr    = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        read_status(st);
        check("rst_status", st, 32'h0);
        check("rst_tx", {31'b0, UART_TX}, 32'd1);
        check("rst_leds", {26'b0, LEDS}, 32'h0);

        io_write(32'h04, 32'h2A);
        check("led_2a", {26'b0, LEDS}, 32'h2A);
        check("led_tx_idle", {31'b0, UART_TX}, 32'd1);
        IO_mem_addr = 32'h04;
        #1 check("led_rdata_zero", IO_mem_rdata, 32'h0);
        io_write(32'h04, 32'hFFFF_FFC5);
        check("led_trunc", {26'b0, LEDS}, 32'h05);

        // Single frame 0x55: line level checked at first and last cycle of each bit.
        pat = 8'h55;
        sb_q.push_back(pat);
        io_write(32'h08, {24'b0, pat});
        check("f55_pre", {31'b0, UART_TX}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 0 || i % 10 == 9) begin
                if (i < 10)      exp_bit = 1'b0;
                else if (i < 90) exp_bit = pat[(i - 10) / 10];
                else             exp_bit = 1'b1;
                check($sformatf("f55_cyc%0d", i + 1), {31'b0, UART_TX}, {31'b0, exp_bit});
            end
        end
        read_status(st);
        check("f55_busy_last", st, 32'h100);
        @(negedge clk);
        read_status(st);
        check("f55_idle", st, 32'h0);
        check("f55_tx_idle", {31'b0, UART_TX}, 32'd1);
        expect_frame("f55", s_cur);

        // Burst while a frame is in flight: no pops happen during the burst.
        burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'h7E, 8'hE7};
        sb_q.push_back(8'hA5);
        io_write(32'h08, 32'hA5);
        mcount = 1;
        repeat (3) @(negedge clk);
        mcount = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 9; i++) begin
            IO_mem_addr  = 32'h08;
            IO_mem_wdata = {24'b0, burst[i]};
            IO_mem_wr    = 1'b1;
            if (mcount < DEPTH) begin
                sb_q.push_back(burst[i]);
                mcount++;
            end else begin
                exp_ovf = 1'b1;
            end
            @(negedge clk);
        end
        IO_mem_wr = 1'b0;
        read_status(st);
        check("burst_status", st, {21'b0, exp_ovf, mcount == DEPTH, 1'b1, 4'b0, 4'(mcount)});
        io_write(32'h10, 32'hFFFF_FBFF);
        read_status(st);
        check("ovf_keep", st, {21'b0, exp_ovf, mcount == DEPTH, 1'b1, 4'b0, 4'(mcount)});
        io_write(32'h10, 32'h400);
        read_status(st);
        check("ovf_clear", st, {21'b0, 1'b0, mcount == DEPTH, 1'b1, 4'b0, 4'(mcount)});

        expect_frame("burst_a5", s_prev);
        for (int i = 0; i < mcount; i++) begin
            expect_frame($sformatf("burst%0d", i), s_cur);
            check($sformatf("burst%0d_spacing", i), s_cur - s_prev, 10 * DIV);
            s_prev = s_cur;
        end
        repeat (150) @(negedge clk);
        check("burst_no_extra", rx_q.size(), 32'd0);
        read_status(st);
        check("burst_drained", st, 32'h0);

        // Reset during data bit 3 of 0xC3 (bit 3 is a zero).
        io_write(32'h08, 32'hC3);
        io_write(32'h08, 32'h3C);
        repeat (43) @(negedge clk);
        check("mid_bit3_low", {31'b0, UART_TX}, 32'd0);
        #2 resetn = 1'b0;
        #1 check("rst_tx_async", {31'b0, UART_TX}, 32'd1);
        read_status(st);
        check("rst_fifo_empty", st, 32'h0);
        check("rst_leds_clear", {26'b0, LEDS}, 32'h0);
        @(negedge clk);
        #1 resetn = 1'b1;
        sb_q.delete();
        rx_q.delete();
        sb_q.push_back(8'h96);
        io_write(32'h08, 32'h96);
        expect_frame("post_rst", s_cur);
        repeat (20) @(negedge clk);
        check("post_rst_no_extra", rx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
